// File: rtl/pixel_frame_ctrl.sv
// Frame sequencer for a row-organised pixel sensor array.
// Each frame walks erase -> expose -> convert (8-bit ramp code on DATA) ->
// row-by-row readout, then returns to IDLE with a one-cycle frame_done.
// All outputs are flops loaded from a decode of the next state, so every
// strobe lines up with the state it belongs to and drops asynchronously on reset.
module pixel_frame_ctrl #(
    parameter int ROWS      = 2,
    parameter int ERASE_CYC = 5,
    parameter int READ_CYC  = 4,
    parameter int EXP_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [EXP_W-1:0] expose_len,
    output logic             erase,
    output logic             expose,
    output logic             convert,
    output logic [7:0]       data_out,
    output logic             data_oe,
    output logic [ROWS-1:0]  read,
    output logic             busy,
    output logic             frame_done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ERASE   = 3'd1;
    localparam logic [2:0] S_EXPOSE  = 3'd2;
    localparam logic [2:0] S_CONVERT = 3'd3;
    localparam logic [2:0] S_READ    = 3'd4;

    // Phase counter is 8 bits; it only widens if the exposure input is wider.
    localparam int CNT_W = (EXP_W > 8) ? EXP_W : 8;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic [EXP_W-1:0] exp_last_s;

    logic             erase_q, erase_d;
    logic             expose_q, expose_d;
    logic             convert_q, convert_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             data_oe_q, data_oe_d;
    logic [ROWS-1:0]  read_q, read_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;

    // Last expose count value; a latched length of 0 still exposes for one cycle.
    always_comb begin
        if (exp_q == {EXP_W{1'b0}}) begin
            exp_last_s = {EXP_W{1'b0}};
        end else begin
            exp_last_s = exp_q - EXP_W'(1);
        end
    end

    // Next-state, phase counter, row index and exposure latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        row_d   = row_q;
        exp_d   = exp_q;
        if (abort) begin
            // Abort wins over start and over every phase transition.
            state_d = S_IDLE;
            cnt_d   = {CNT_W{1'b0}};
            row_d   = {ROW_W{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = {CNT_W{1'b0}};
                    row_d = {ROW_W{1'b0}};
                    if (start) begin
                        exp_d   = expose_len;
                        state_d = S_ERASE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_ERASE: begin
                    if (cnt_q == CNT_W'(ERASE_CYC - 1)) begin
                        state_d = S_EXPOSE;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        state_d = S_ERASE;
                    end
                end
                S_EXPOSE: begin
                    if (cnt_q == CNT_W'(exp_last_s)) begin
                        state_d = S_CONVERT;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        state_d = S_EXPOSE;
                    end
                end
                S_CONVERT: begin
                    // The ramp code is the counter itself; it wraps only here.
                    if (cnt_q == CNT_W'(255)) begin
                        state_d = S_READ;
                        cnt_d   = {CNT_W{1'b0}};
                        row_d   = {ROW_W{1'b0}};
                    end else begin
                        state_d = S_CONVERT;
                    end
                end
                S_READ: begin
                    if (cnt_q == CNT_W'(READ_CYC - 1)) begin
                        cnt_d = {CNT_W{1'b0}};
                        if (row_q == ROW_W'(ROWS - 1)) begin
                            state_d = S_IDLE;
                            row_d   = {ROW_W{1'b0}};
                        end else begin
                            state_d = S_READ;
                            row_d   = row_q + ROW_W'(1);
                        end
                    end else begin
                        state_d = S_READ;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                    row_d   = {ROW_W{1'b0}};
                end
            endcase
        end
    end

    // Output decode of the upcoming state so the registered strobes align with it.
    always_comb begin
        erase_d      = (state_d == S_ERASE);
        expose_d     = (state_d == S_EXPOSE);
        convert_d    = (state_d == S_CONVERT);
        data_oe_d    = (state_d == S_CONVERT);
        data_out_d   = (state_d == S_CONVERT) ? cnt_d[7:0] : 8'd0;
        read_d       = {ROWS{1'b0}};
        for (int i = 0; i < ROWS; i++) begin
            read_d[i] = (state_d == S_READ) && (row_d == ROW_W'(i));
        end
        // frame_done marks the final read cycle; busy is already low there.
        frame_done_d = (state_d == S_READ) && (row_d == ROW_W'(ROWS - 1)) &&
                       (cnt_d == CNT_W'(READ_CYC - 1));
        busy_d       = (state_d != S_IDLE) && !frame_done_d;
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            row_q        <= {ROW_W{1'b0}};
            exp_q        <= {EXP_W{1'b0}};
            erase_q      <= 1'b0;
            expose_q     <= 1'b0;
            convert_q    <= 1'b0;
            data_out_q   <= 8'd0;
            data_oe_q    <= 1'b0;
            read_q       <= {ROWS{1'b0}};
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            row_q        <= row_d;
            exp_q        <= exp_d;
            erase_q      <= erase_d;
            expose_q     <= expose_d;
            convert_q    <= convert_d;
            data_out_q   <= data_out_d;
            data_oe_q    <= data_oe_d;
            read_q       <= read_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign erase      = erase_q;
    assign expose     = expose_q;
    assign convert    = convert_q;
    assign data_out   = data_out_q;
    assign data_oe    = data_oe_q;
    assign read       = read_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
